// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART controller: register offsets,
// CON bit positions and the TX sequencer state encoding.
package uart_mmio_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0000_0018;
  localparam logic [31:0] OFF_RXD = 32'h0000_001C;
  localparam logic [31:0] OFF_CON = 32'h0000_0020;

  localparam int CON_TX_IE     = 0;
  localparam int CON_RX_IE     = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_NEMPTY = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_RX_OVF    = 5;
  localparam int CON_TX_OVF    = 6;

  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_START     = 2'd1;
  localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
  localparam logic [1:0] TX_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = TX_IDLE,
    ST_START     = TX_START,
    ST_WAIT_BUSY = TX_WAIT_BUSY,
    ST_WAIT_DONE = TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// Bus-side and UART-core-side signals of the controller, bundled with
// modports for the controller (slave) and whatever drives it (master).
interface uart_mmio_if;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  rx_data;
  logic        rx_status;
  logic        tx_status;
  logic [7:0]  tx_data;
  logic        tx_en;

  modport slave (
    input  addr, rd, wr, wdata, rx_data, rx_status, tx_status,
    output rdata, irq, tx_data, tx_en
  );

  modport master (
    output addr, rd, wr, wdata, rx_data, rx_status, tx_status,
    input  rdata, irq, tx_data, tx_en
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; a push while full is accepted only if a pop frees a
// slot on the same edge.
module uart_rx_fifo #(
  parameter int RX_DEPTH = 4,
  parameter int RX_AW    = 2
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [RX_AW:0]   count
);

  logic [7:0]       r_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_wr_ptr;
  logic [RX_AW-1:0] r_rd_ptr;
  logic [RX_AW:0]   r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (RX_AW+1)'(RX_DEPTH));
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + RX_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + RX_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (RX_AW+1)'(1);
        2'b01:   r_count <= r_count - (RX_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART controller: TXD/RXD/CON registers, a one-byte TX hold
// register sequenced against the sender, an RX FIFO and a level interrupt.
//
// state      | meaning
// IDLE       | no frame in flight; waiting for a held byte and an idle sender
// START      | tx_en pulse, tx_data latched for the whole frame
// WAIT_BUSY  | waiting for the sender to report busy
// WAIT_DONE  | waiting for the sender to return idle; frees the hold register
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h4000_0000,
  parameter int          RX_DEPTH = 4,
  parameter int          RX_AW    = 2
) (
  input logic        sysclk,
  input logic        rst,
  uart_mmio_if.slave bus
);

  tx_state_t      r_state, w_state_nxt;
  logic           r_tx_en, r_hold_valid, r_irq;
  logic [7:0]     r_tx_data, r_hold;
  logic           r_tx_ie, r_rx_ie, r_tx_done, r_rx_ovf, r_tx_ovf;
  logic           w_start, w_done;
  logic           w_sel_txd, w_sel_rxd, w_sel_con;
  logic           w_rd, w_txd_wr, w_con_wr, w_rxd_rd, w_con_rd;
  logic           w_hold_load, w_tx_ovf_set, w_rx_ovf_set, w_rx_nempty;
  logic [7:0]     w_rx_dout, w_start_byte;
  logic           w_rx_empty, w_rx_full;
  logic [RX_AW:0] w_rx_count;
  logic [31:0]    w_con, w_rdata;

  // Simultaneous rd and wr is treated as a write only.
  assign w_rd      = bus.rd & ~bus.wr;
  assign w_sel_txd = (bus.addr == BASE + OFF_TXD);
  assign w_sel_rxd = (bus.addr == BASE + OFF_RXD);
  assign w_sel_con = (bus.addr == BASE + OFF_CON);
  assign w_txd_wr  = bus.wr & w_sel_txd;
  assign w_con_wr  = bus.wr & w_sel_con;
  assign w_rxd_rd  = w_rd & w_sel_rxd;
  assign w_con_rd  = w_rd & w_sel_con;

  assign w_hold_load  = w_txd_wr & ~r_hold_valid;
  assign w_tx_ovf_set = w_txd_wr & r_hold_valid;
  assign w_rx_ovf_set = bus.rx_status & w_rx_full & ~w_rxd_rd;
  assign w_rx_nempty  = (w_rx_count != '0);
  assign w_start_byte = r_hold_valid ? r_hold : bus.wdata[7:0];

  uart_rx_fifo #(.RX_DEPTH(RX_DEPTH), .RX_AW(RX_AW)) u_rx_fifo (
    .sysclk (sysclk),
    .rst    (rst),
    .push   (bus.rx_status),
    .din    (bus.rx_data),
    .pop    (w_rxd_rd),
    .dout   (w_rx_dout),
    .empty  (w_rx_empty),
    .full   (w_rx_full),
    .count  (w_rx_count)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A write landing in IDLE starts the frame directly, giving one-cycle latency.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.tx_status & (r_hold_valid | w_txd_wr)) begin
        w_state_nxt = ST_START;
        w_start     = 1'b1;
      end
      ST_START:     w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!bus.tx_status) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.tx_status) begin
        w_state_nxt = ST_IDLE;
        w_done      = 1'b1;
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_tx_en      <= 1'b0;
      r_tx_data    <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_tx_ie      <= 1'b0;
      r_rx_ie      <= 1'b0;
      r_tx_done    <= 1'b0;
      r_rx_ovf     <= 1'b0;
      r_tx_ovf     <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_tx_en <= w_start;
      if (w_start) r_tx_data <= w_start_byte;
      if (w_hold_load) begin
        r_hold       <= bus.wdata[7:0];
        r_hold_valid <= 1'b1;
      end else if (w_done) begin
        r_hold_valid <= 1'b0;
      end
      if (w_con_wr) begin
        r_tx_ie <= bus.wdata[CON_TX_IE];
        r_rx_ie <= bus.wdata[CON_RX_IE];
      end
      // Sticky bits: a set event in the same cycle as a CON read wins.
      r_tx_done <= w_done       | (r_tx_done & ~w_con_rd);
      r_rx_ovf  <= w_rx_ovf_set | (r_rx_ovf  & ~w_con_rd);
      r_tx_ovf  <= w_tx_ovf_set | (r_tx_ovf  & ~w_con_rd);
      r_irq     <= (r_tx_ie & r_tx_done) | (r_rx_ie & w_rx_nempty);
    end
  end

  always_comb begin
    w_con                = '0;
    w_con[CON_TX_IE]     = r_tx_ie;
    w_con[CON_RX_IE]     = r_rx_ie;
    w_con[CON_TX_DONE]   = r_tx_done;
    w_con[CON_RX_NEMPTY] = w_rx_nempty;
    w_con[CON_TX_BUSY]   = r_hold_valid;
    w_con[CON_RX_OVF]    = r_rx_ovf;
    w_con[CON_TX_OVF]    = r_tx_ovf;
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_txd)                  w_rdata = {24'b0, r_hold};
    else if (w_sel_rxd)             w_rdata = w_rx_empty ? 32'b0 : {24'b0, w_rx_dout};
    else if (w_sel_con)             w_rdata = w_con;
  end

  assign bus.rdata   = w_rdata;
  assign bus.irq     = r_irq;
  assign bus.tx_en   = r_tx_en;
  assign bus.tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: a queue/flag model of the register map
// predicts read data and transmitted bytes; a monitor compares them.
module tb_uart_mmio;
  import uart_mmio_pkg::*;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TXD = BASE + 32'h18;
  localparam logic [31:0] A_RXD = BASE + 32'h1C;
  localparam logic [31:0] A_CON = BASE + 32'h20;
  localparam int          DEPTH = 4;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;

  uart_mmio_if ifc();

  uart_mmio #(.BASE(BASE), .RX_DEPTH(DEPTH), .RX_AW(2)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (ifc)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  m_q[$];
  logic [7:0]  m_hold = 8'h00;
  bit          m_hold_valid, m_tx_ie, m_rx_ie, m_tx_done, m_rx_ovf, m_tx_ovf;
  int          m_frames_started = 0;
  int          frames_done = 0;
  int          busy_len = 4;
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  bit          frame_active = 1'b0;
  logic [7:0]  cur_tx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_con();
    return {25'b0, m_tx_ovf, m_rx_ovf, m_hold_valid, (m_q.size() != 0), m_tx_done, m_rx_ie, m_tx_ie};
  endfunction

  function automatic logic m_irq();
    return (m_tx_ie & m_tx_done) | (m_rx_ie & (m_q.size() != 0));
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_hold = 8'h00;
    m_hold_valid = 0; m_tx_ie = 0; m_rx_ie = 0;
    m_tx_done = 0; m_rx_ovf = 0; m_tx_ovf = 0;
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a == A_TXD) v = {24'b0, m_hold};
    else if (a == A_RXD) begin
      if (m_q.size() != 0) v = {24'b0, m_q.pop_front()};
    end else if (a == A_CON) begin
      v = m_con();
      m_tx_done = 0; m_rx_ovf = 0; m_tx_ovf = 0;
    end
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a == A_TXD) begin
      if (m_hold_valid) m_tx_ovf = 1;
      else begin
        m_hold = d[7:0];
        m_hold_valid = 1;
        exp_tx.push_back(d[7:0]);
        m_frames_started++;
      end
    end else if (a == A_CON) begin
      m_tx_ie = d[0];
      m_rx_ie = d[1];
    end
  endtask

  task automatic m_push(input logic [7:0] b);
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_rx_ovf = 1;
  endtask

  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic rxs, input logic [7:0] rxd);
    @(posedge sysclk); #1;
    ifc.rd = r; ifc.wr = w; ifc.addr = a; ifc.wdata = d;
    ifc.rx_status = rxs; ifc.rx_data = rxd;
    @(posedge sysclk); #1;
    ifc.rd = 1'b0; ifc.wr = 1'b0; ifc.rx_status = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    logic [31:0] v;
    m_read(a, v);
    exp_rd.push_back(v);
    cyc(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    m_write(a, d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic bus_rdwr(input logic [31:0] a, input logic [31:0] d);
    m_write(a, d);
    cyc(1'b1, 1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rx_push(input logic [7:0] b);
    m_push(b);
    cyc(1'b0, 1'b0, ifc.addr, 32'h0, 1'b1, b);
  endtask

  // Read and receive-pulse in the same cycle: the read sees the old state.
  task automatic read_push(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] v;
    m_read(a, v);
    exp_rd.push_back(v);
    m_push(b);
    cyc(1'b1, 1'b0, a, 32'h0, 1'b1, b);
  endtask

  task automatic wait_tx_complete();
    int n = 0;
    while (frames_done < m_frames_started && n < 2000) begin
      @(posedge sysclk);
      n++;
    end
    chk("tx_frame_timeout", 32'(frames_done >= m_frames_started), 32'd1);
    repeat (2) @(posedge sysclk);
    #1;
    m_hold_valid = 0;
    m_tx_done = 1;
    frame_active = 1'b0;
  endtask

  task automatic check_irq(input string name);
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    chk(name, {31'b0, ifc.irq}, {31'b0, m_irq()});
  endtask

  // Behavioural UART sender: busy for busy_len cycles after each tx_en.
  initial begin
    ifc.tx_status = 1'b1;
    forever begin
      @(negedge sysclk);
      if (ifc.tx_en === 1'b1) begin
        @(posedge sysclk); #1;
        ifc.tx_status = 1'b0;
        repeat (busy_len) @(posedge sysclk);
        #1;
        ifc.tx_status = 1'b1;
        frames_done++;
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge sysclk);
      if (!rst) begin
        if (ifc.rd && !ifc.wr) begin
          if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
          else chk("rdata", ifc.rdata, exp_rd.pop_front());
        end
        if (ifc.tx_en) begin
          if (exp_tx.size() == 0) chk("tx_en_unexpected", {24'b0, ifc.tx_data}, 32'hFFFF_FFFF);
          else begin
            e = exp_tx.pop_front();
            chk("tx_data_at_en", {24'b0, ifc.tx_data}, {24'b0, e});
            cur_tx = e;
            frame_active = 1'b1;
          end
        end else if (frame_active) begin
          chk("tx_data_hold", {24'b0, ifc.tx_data}, {24'b0, cur_tx});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bad_offs [5];
    int n;
    bad_offs = '{32'h0, 32'h14, 32'h19, 32'h24, 32'h1000_0018};
    ifc.rd = 1'b0; ifc.wr = 1'b0; ifc.addr = 32'h0; ifc.wdata = 32'h0;
    ifc.rx_status = 1'b0; ifc.rx_data = 8'h00;
    m_reset();

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_tx_en", {31'b0, ifc.tx_en}, 32'd0);
    chk("rst_tx_data", {24'b0, ifc.tx_data}, 32'd0);
    chk("rst_irq", {31'b0, ifc.irq}, 32'd0);
    @(posedge sysclk); #1;
    rst = 1'b0;
    bus_read(A_CON);
    bus_read(A_TXD);

    // Reset while the controller waits for the frame to end.
    busy_len = 20;
    bus_write(A_TXD, 32'hA5);
    repeat (6) @(posedge sysclk);
    #1;
    frame_active = 1'b0;
    rst = 1'b1;
    @(negedge sysclk);
    chk("midrst_tx_en", {31'b0, ifc.tx_en}, 32'd0);
    chk("midrst_tx_data", {24'b0, ifc.tx_data}, 32'd0);
    repeat (2) @(posedge sysclk);
    #1;
    rst = 1'b0;
    m_reset();
    n = 0;
    while (ifc.tx_status !== 1'b1 && n < 200) begin
      @(posedge sysclk);
      n++;
    end
    chk("sender_idle_timeout", {31'b0, ifc.tx_status}, 32'd1);
    m_frames_started = frames_done;
    bus_read(A_CON);
    busy_len = 3;
    bus_write(A_TXD, 32'h3C);
    wait_tx_complete();
    bus_read(A_CON);

    // Main TX path with a long frame.
    busy_len = 100;
    bus_write(A_TXD, 32'h55);
    @(negedge sysclk);
    chk("tx_latency", {31'b0, ifc.tx_en}, 32'd1);
    chk("tx_latency_data", {24'b0, ifc.tx_data}, 32'h55);
    @(negedge sysclk);
    chk("tx_en_width", {31'b0, ifc.tx_en}, 32'd0);
    wait_tx_complete();
    bus_read(A_CON);
    bus_read(A_CON);
    bus_write(A_CON, 32'h1);
    busy_len = 5;
    bus_write(A_TXD, 32'h5A);
    wait_tx_complete();
    check_irq("irq_tx_done");
    bus_read(A_CON);
    check_irq("irq_tx_cleared");

    // Overrun while the hold register is busy.
    busy_len = 30;
    bus_write(A_TXD, 32'h11);
    bus_write(A_TXD, 32'h22);
    wait_tx_complete();
    bus_read(A_CON);
    bus_read(A_TXD);

    // RX ordering and empty read.
    bus_write(A_CON, 32'h0);
    rx_push(8'h01); rx_push(8'h02); rx_push(8'h03);
    bus_read(A_CON);
    repeat (3) bus_read(A_RXD);
    bus_read(A_CON);
    bus_read(A_RXD);

    bus_write(A_CON, 32'h2);
    rx_push(8'h77);
    check_irq("irq_rx");
    bus_read(A_RXD);
    check_irq("irq_rx_cleared");

    // Overflow, then pop+push on a full FIFO.
    for (int i = 0; i < 5; i++) rx_push(8'(8'h10 + i));
    bus_read(A_CON);
    repeat (4) bus_read(A_RXD);
    for (int i = 0; i < 4; i++) rx_push(8'(8'h20 + i));
    read_push(A_RXD, 8'h99);
    bus_read(A_CON);
    repeat (5) bus_read(A_RXD);

    // Overflow in the same cycle as a CON read: the set survives.
    for (int i = 0; i < 4; i++) rx_push(8'(8'h30 + i));
    read_push(A_CON, 8'hEE);
    bus_read(A_CON);
    repeat (4) bus_read(A_RXD);

    // rd and wr together act as a write only.
    rx_push(8'h42);
    bus_rdwr(A_RXD, 32'h0);
    bus_read(A_RXD);
    bus_rdwr(A_CON, 32'h3);
    bus_read(A_CON);

    foreach (bad_offs[i]) begin
      bus_write(BASE + bad_offs[i], 32'hFFFF_FFFF);
      bus_read(BASE + bad_offs[i]);
    end
    bus_read(A_CON);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rx_push(8'($urandom));
        3, 4:    bus_read(A_RXD);
        5:       bus_read(A_CON);
        6:       bus_write(A_CON, $urandom);
        7: begin
          busy_len = $urandom_range(1, 6);
          bus_write(A_TXD, $urandom);
          if ($urandom_range(0, 1) == 1) bus_write(A_TXD, $urandom);
          wait_tx_complete();
        end
        8: begin
          if ($urandom_range(0, 1) == 1) bus_write(BASE + bad_offs[$urandom_range(0, 4)], $urandom);
          else bus_read(BASE + bad_offs[$urandom_range(0, 4)]);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) bus_read(A_TXD);
          else read_push(($urandom_range(0, 1) == 1) ? A_RXD : A_CON, 8'($urandom));
        end
      endcase
      if (it % 16 == 15) check_irq("irq_random");
    end

    repeat (3) @(posedge sysclk);
    chk("rd_queue_left", 32'(exp_rd.size()), 32'd0);
    chk("tx_queue_left", 32'(exp_tx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
